seg7_scan_driver: RTL and testbench

- Time-multiplexed driver for a NUM_DIGITS-digit common-anode/cathode 7-segment display with decimal points.
- Latches a packed hex value on a load strobe, scans one digit per slot, decodes 0-F, and optionally blanks leading zeros.
- Sits between datapath/status registers and the board display pins.
- Per-slot blanking interval suppresses ghosting; a per-frame pulse lets software synchronise updates.

---
 rtl/seg7_pkg.sv | 37 +++
 rtl/seg7_hex_decode.sv | 23 ++
 rtl/seg7_scan_driver.sv | 166 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared types, 7-segment decode table and index-width helper
//               for the multiplexed 7-segment display driver.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

   // Scan controller states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } scan_state_t;

   // Active-high g..a patterns for hex digits 0-F (entry 0 is rightmost).
   localparam logic [15:0][6:0] SEG7_TABLE = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   // Number of bits needed to count 0..value-1.
   function automatic int clog2(input int value);
      int width;
      int rem;
      width = 0;
      rem   = value - 1;
      while (rem > 0) begin
         width = width + 1;
         rem   = rem >> 1;
      end
      return width;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_hex_decode
// Description : Combinational hex nibble + decimal point to active-high
//               7-segment pattern; blank forces g..a off but keeps dp.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       dp,
   input  logic       blank,
   output logic [7:0] pattern
);

   // Table lookup, with the dp bit carried through even on a blanked digit.
   always_comb begin
      pattern = {dp, (blank ? 7'h00 : SEG7_TABLE[nibble])};
   end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Time-multiplexed NUM_DIGITS-digit 7-segment driver with a
//               per-slot blanking interval, leading-zero suppression and a
//               per-frame completion pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int SLOT_CYCLES    = 50000,
   parameter int BLANK_CYCLES   = 500,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    blank_lz,
   output logic [7:0]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int CNT_W = (clog2(SLOT_CYCLES) < 1) ? 1 : clog2(SLOT_CYCLES);
   localparam int IDX_W = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1;

   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SLOT_CYCLES - BLANK_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   // Inactive output levels; XOR with these converts active-high to pin polarity.
   localparam logic [7:0]            SEG_OFF = {8{(SEG_ACTIVE_LOW != 0)}};
   localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{(AN_ACTIVE_LOW != 0)}};

   // Latched copy (written by load) and shadow copy (what is on the display).
   logic [NUM_DIGITS-1:0][3:0] latch_val;
   logic [NUM_DIGITS-1:0]      latch_dp;
   logic                       latch_blz;
   logic [NUM_DIGITS-1:0][3:0] shadow_val;
   logic [NUM_DIGITS-1:0]      shadow_dp;
   logic                       shadow_blz;

   scan_state_t                state;
   logic [CNT_W-1:0]           cnt;
   logic [IDX_W-1:0]           idx;

   logic [NUM_DIGITS-1:0]      lz_blank;
   logic                       upper_zero;
   logic [7:0]                 cur_pattern;
   logic [NUM_DIGITS-1:0]      digit_sel;

   // Capture the host value on every load strobe, regardless of enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         latch_val <= '0;
         latch_dp  <= '0;
         latch_blz <= 1'b0;
      end else if (load) begin
         latch_val <= value_in;
         latch_dp  <= dp_in;
         latch_blz <= blank_lz;
      end
   end

   // A digit is a leading zero when it and every more-significant nibble are 0.
   always_comb begin
      upper_zero = 1'b1;
      lz_blank   = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         upper_zero  = upper_zero & (shadow_val[i] == 4'h0);
         lz_blank[i] = shadow_blz & upper_zero;
      end
   end

   seg7_hex_decode u_decode (
      .nibble  (shadow_val[idx]),
      .dp      (shadow_dp[idx]),
      .blank   (lz_blank[idx]),
      .pattern (cur_pattern)
   );

   // One-hot anode select for the current digit, active-high.
   always_comb begin
      digit_sel = NUM_DIGITS'(1) << idx;
   end

   // Scan FSM: BLANK then DRIVE per digit; outputs are set on entry to each state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         idx        <= '0;
         shadow_val <= '0;
         shadow_dp  <= '0;
         shadow_blz <= 1'b0;
         seg        <= SEG_OFF;
         an         <= AN_OFF;
         frame_done <= 1'b0;
      end else if (!enable) begin
         state      <= IDLE;
         cnt        <= '0;
         idx        <= '0;
         seg        <= SEG_OFF;
         an         <= AN_OFF;
         frame_done <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state      <= BLANK;
               cnt        <= '0;
               shadow_val <= latch_val;
               shadow_dp  <= latch_dp;
               shadow_blz <= latch_blz;
               seg        <= SEG_OFF;
               an         <= AN_OFF;
               frame_done <= 1'b0;
            end
            BLANK: begin
               frame_done <= 1'b0;
               if (cnt == BLANK_LAST) begin
                  state <= DRIVE;
                  cnt   <= '0;
                  seg   <= cur_pattern ^ SEG_OFF;
                  an    <= digit_sel ^ AN_OFF;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DRIVE: begin
               if (cnt == DRIVE_LAST) begin
                  state      <= BLANK;
                  cnt        <= '0;
                  seg        <= SEG_OFF;
                  an         <= AN_OFF;
                  // Refresh the displayed copy only at slot boundaries so a
                  // digit is never torn mid-slot.
                  shadow_val <= latch_val;
                  shadow_dp  <= latch_dp;
                  shadow_blz <= latch_blz;
                  frame_done <= (idx == IDX_LAST);
                  idx        <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
               end else begin
                  cnt        <= cnt + 1'b1;
                  frame_done <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               cnt        <= '0;
               idx        <= '0;
               seg        <= SEG_OFF;
               an         <= AN_OFF;
               frame_done <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Self-checking bench for seg7_scan_driver (4 digits, 8-cycle
//               slots, 2-cycle blank, active-low pins).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

   localparam int N     = 4;
   localparam int SLOT  = 8;
   localparam int BLANK = 2;
   localparam int FRAME = N * SLOT;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        load;
   logic [15:0] value_in;
   logic [3:0]  dp_in;
   logic        blank_lz;
   logic [7:0]  seg;
   logic [3:0]  an;
   logic        frame_done;

   int passed = 0;
   int total  = 0;
   int fails  = 0;

   // Reference model: time since scan start plus latched/displayed snapshots.
   bit          running;
   int          t;
   logic [15:0] m_val, s_val;
   logic [3:0]  m_dp, s_dp;
   bit          m_blz, s_blz;

   seg7_scan_driver #(
      .NUM_DIGITS     (N),
      .SLOT_CYCLES    (SLOT),
      .BLANK_CYCLES   (BLANK),
      .SEG_ACTIVE_LOW (1),
      .AN_ACTIVE_LOW  (1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .load       (load),
      .value_in   (value_in),
      .dp_in      (dp_in),
      .blank_lz   (blank_lz),
      .seg        (seg),
      .an         (an),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [6:0] hex7(input logic [3:0] h);
      case (h)
         4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
         4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
         4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
         4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
      endcase
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h (t=%0d)", tag, obs, exp, t);
      end
   endtask

   task automatic model_reset();
      running = 0;
      t       = 0;
      m_val   = '0;  m_dp = '0;  m_blz = 0;
      s_val   = '0;  s_dp = '0;  s_blz = 0;
   endtask

   task automatic snap();
      s_val = m_val;
      s_dp  = m_dp;
      s_blz = m_blz;
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_edge();
      if (rst) begin
         model_reset();
      end else begin
         if (!enable) begin
            running = 0;
         end else if (!running) begin
            running = 1;
            t       = 0;
            snap();
         end else begin
            t++;
            if (t % SLOT == 0) snap();
         end
         if (load) begin
            m_val = value_in;
            m_dp  = dp_in;
            m_blz = blank_lz;
         end
      end
   endtask

   task automatic check_all();
      int         pos, dig, ins;
      logic [3:0] e_an;
      logic [7:0] e_seg;
      logic       e_fd;
      bit         lzb;
      e_an  = 4'hF;
      e_seg = 8'hFF;
      e_fd  = 1'b0;
      if (running) begin
         pos  = t % FRAME;
         dig  = pos / SLOT;
         ins  = pos % SLOT;
         e_fd = (t > 0) && (pos == 0);
         if (ins >= BLANK) begin
            lzb   = s_blz && (dig > 0) && ((s_val >> (4 * dig)) == 16'h0);
            e_an  = 4'hF & ~(4'b0001 << dig);
            e_seg = ~{s_dp[dig], (lzb ? 7'h00 : hex7(s_val[4*dig +: 4]))};
         end
      end
      check("an",         {4'h0, an},         {4'h0, e_an});
      check("seg",        seg,                e_seg);
      check("frame_done", {7'h0, frame_done}, {7'h0, e_fd});
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Run until the model is at a given position in the frame (bounded).
   task automatic seek(input int ph);
      int k;
      k = 0;
      while (!(running && (t % FRAME) == ph) && k < 100) begin
         tick();
         k++;
      end
      total++;
      assert (running && (t % FRAME) == ph) passed++;
      else begin
         fails++;
         $error("FAIL seek observed=%0d expected=%0d", t % FRAME, ph);
      end
   endtask

   initial begin
      rst = 1'b1;  enable = 1'b0;  load = 1'b0;
      value_in = '0;  dp_in = '0;  blank_lz = 1'b0;
      model_reset();
      #1;
      check("reset_an",  {4'h0, an}, 8'h0F);
      check("reset_seg", seg, 8'hFF);
      check("reset_fd",  {7'h0, frame_done}, 8'h00);
      run(2);
      rst = 1'b0;
      run(2);

      // Power-up scan without any load: all digits show "0".
      enable = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (t < BLANK)               check("first_blank_an", {4'h0, an}, 8'h0F);
         if (t >= BLANK && t < SLOT)  check("first_d0_seg", seg, 8'hC0);
         if (t == SLOT + BLANK)       check("first_d1_an", {4'h0, an}, 8'h0D);
      end

      // Load captured while disabled, then 12EF with dp on digit 2.
      enable = 1'b0;
      tick();
      load = 1'b1;  value_in = 16'h12EF;  dp_in = 4'b0100;  blank_lz = 1'b0;
      tick();
      load = 1'b0;  enable = 1'b1;
      for (int i = 0; i <= FRAME; i++) begin
         tick();
         if (t == 3)     check("d0_F",  seg, 8'h8E);
         if (t == 11)    check("d1_E",  seg, 8'h86);
         if (t == 19)    check("d2_2dp", seg, 8'h24);
         if (t == 27)    check("d3_1",  seg, 8'hF9);
         if (t == FRAME) check("fd_32", {7'h0, frame_done}, 8'h01);
      end

      // Load 1111 in the middle of digit 1's drive phase: no tearing.
      seek(SLOT + 4);
      load = 1'b1;  value_in = 16'h1111;  dp_in = 4'b0000;
      tick();
      load = 1'b0;
      check("no_tear_d1", seg, 8'h86);
      for (int i = 0; i < 20; i++) begin
         tick();
         if ((t % FRAME) == 2 * SLOT + 3) check("new_d2_1", seg, 8'hF9);
      end

      // Leading-zero blanking, 0030 then 0000.
      enable = 1'b0;
      load = 1'b1;  value_in = 16'h0030;  blank_lz = 1'b1;
      tick();
      load = 1'b0;  enable = 1'b1;
      for (int i = 0; i <= FRAME; i++) begin
         tick();
         if (t == 3)  check("lz_d0", seg, 8'hC0);
         if (t == 11) check("lz_d1", seg, 8'hB0);
         if (t == 19) check("lz_d2_seg", seg, 8'hFF);
         if (t == 19) check("lz_d2_an", {4'h0, an}, 8'h0B);
         if (t == 27) check("lz_d3_an", {4'h0, an}, 8'h07);
      end
      enable = 1'b0;
      load = 1'b1;  value_in = 16'h0000;
      tick();
      load = 1'b0;  enable = 1'b1;
      for (int i = 0; i <= FRAME; i++) begin
         tick();
         if (t == 3)  check("zero_d0", seg, 8'hC0);
         if (t == 11) check("zero_d1", seg, 8'hFF);
      end

      // Abort mid-slot, then restart.
      seek(2 * SLOT + 4);
      enable = 1'b0;
      tick();
      check("abort_an",  {4'h0, an}, 8'h0F);
      check("abort_seg", seg, 8'hFF);
      check("abort_fd",  {7'h0, frame_done}, 8'h00);
      enable = 1'b1;
      run(12);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         enable = ($urandom_range(0, 149) != 0);
         load   = ($urandom_range(0, 15) == 0);
         for (int d = 0; d < N; d++)
            value_in[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
         dp_in    = 4'($urandom);
         blank_lz = 1'($urandom);
         tick();
      end

      // Asynchronous reset in the middle of a drive phase.
      enable = 1'b1;  load = 1'b1;  value_in = 16'hA5C3;  blank_lz = 1'b0;  dp_in = 4'b1001;
      tick();
      load = 1'b0;
      seek(SLOT + 5);
      #3;
      rst = 1'b1;
      #1;
      model_reset();
      check("async_an",  {4'h0, an}, 8'h0F);
      check("async_seg", seg, 8'hFF);
      check("async_fd",  {7'h0, frame_done}, 8'h00);
      run(2);
      rst = 1'b0;
      for (int i = 0; i <= FRAME; i++) begin
         tick();
         if ((t % SLOT) == 4) check("post_rst_0", seg, 8'hC0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
